// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates icache/dcache line requests onto one registered L2 port and routes the response back.
// Latency: request seen in IDLE at cycle N drives the downstream port at N+1; a resp at M permits the next grant at M+3.
// Backpressure: a requester holds read/write until its resp pulse; the loser stays pending, and withdrawn requests are dropped.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int FAIR   = 1
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic              i_pmem_read,
   input  logic              i_pmem_write,
   input  logic [ADDR_W-1:0] i_pmem_address,
   input  logic [LINE_W-1:0] i_pmem_wdata,
   output logic              i_pmem_resp,
   output logic [LINE_W-1:0] i_pmem_rdata,

   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic              d_pmem_resp,
   output logic [LINE_W-1:0] d_pmem_rdata,

   output logic              ab_pmem_read,
   output logic              ab_pmem_write,
   output logic [ADDR_W-1:0] ab_pmem_address,
   output logic [LINE_W-1:0] ab_pmem_wdata,
   input  logic              ab_pmem_resp,
   input  logic [LINE_W-1:0] ab_pmem_rdata
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT_I = 2'd1;
   localparam logic [1:0] GRANT_D = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   logic [1:0]        state;
   logic              last_grant;   // 0 = icache served last, 1 = dcache

   logic              i_pend;
   logic              d_pend;
   logic              pick_d;
   logic              pick_i;
   logic              sel_read;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [LINE_W-1:0] sel_wdata;

   // Choose the next requester and the command it would launch; write wins over read
   always_comb begin
      i_pend    = i_pmem_read | i_pmem_write;
      d_pend    = d_pmem_read | d_pmem_write;
      // dcache wins when alone, when fixed priority, or when icache was served last
      pick_d    = d_pend & (~i_pend | (FAIR == 0) | ~last_grant);
      pick_i    = i_pend & ~pick_d;
      sel_write = 1'b0;
      sel_read  = 1'b0;
      sel_addr  = i_pmem_address;
      sel_wdata = i_pmem_wdata;
      if (pick_d) begin
         sel_write = d_pmem_write;
         sel_read  = d_pmem_read & ~d_pmem_write;
         sel_addr  = d_pmem_address;
         sel_wdata = d_pmem_wdata;
      end else if (pick_i) begin
         sel_write = i_pmem_write;
         sel_read  = i_pmem_read & ~i_pmem_write;
      end
   end

   // Grant FSM and registered downstream command; held stable for the whole transaction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         last_grant      <= 1'b0;
         ab_pmem_read    <= 1'b0;
         ab_pmem_write   <= 1'b0;
         ab_pmem_address <= '0;
         ab_pmem_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_d || pick_i) begin
                  state           <= pick_d ? GRANT_D : GRANT_I;
                  last_grant      <= pick_d;
                  ab_pmem_read    <= sel_read;
                  ab_pmem_write   <= sel_write;
                  ab_pmem_address <= sel_addr;
                  ab_pmem_wdata   <= sel_wdata;
               end
            end
            GRANT_I, GRANT_D: begin
               if (ab_pmem_resp) begin
                  state         <= DONE;
                  ab_pmem_read  <= 1'b0;
                  ab_pmem_write <= 1'b0;
               end
            end
            default: begin
               // Dead cycle so the served cache can drop its request before re-arbitration
               state <= IDLE;
            end
         endcase
      end
   end

   // Response steering: only the owner of the current grant sees the completion pulse
   assign i_pmem_resp  = (state == GRANT_I) & ab_pmem_resp;
   assign d_pmem_resp  = (state == GRANT_D) & ab_pmem_resp;
   assign i_pmem_rdata = ab_pmem_rdata;
   assign d_pmem_rdata = ab_pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed checks of mem_port_arbiter; instance 0 is round-robin, instance 1 is fixed dcache priority.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 1ns after that.
// Backpressure: the bench plays both caches and the L2, pulsing ab resp by hand.
module tb_mem_port_arbiter;

   logic         clk;
   logic         reset_n;

   logic         i_rd  [2];
   logic         i_wr  [2];
   logic [31:0]  i_ad  [2];
   logic [255:0] i_wd  [2];
   logic         i_rsp [2];
   logic [255:0] i_rdt [2];
   logic         d_rd  [2];
   logic         d_wr  [2];
   logic [31:0]  d_ad  [2];
   logic [255:0] d_wd  [2];
   logic         d_rsp [2];
   logic [255:0] d_rdt [2];
   logic         ab_rd [2];
   logic         ab_wr [2];
   logic [31:0]  ab_ad [2];
   logic [255:0] ab_wd [2];
   logic         ab_rsp[2];
   logic [255:0] ab_rdt[2];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_port_arbiter #(
         .ADDR_W (32),
         .LINE_W (256),
         .FAIR   ((g == 0) ? 1 : 0)
      ) u_dut (
         .clk             (clk),
         .reset_n         (reset_n),
         .i_pmem_read     (i_rd[g]),
         .i_pmem_write    (i_wr[g]),
         .i_pmem_address  (i_ad[g]),
         .i_pmem_wdata    (i_wd[g]),
         .i_pmem_resp     (i_rsp[g]),
         .i_pmem_rdata    (i_rdt[g]),
         .d_pmem_read     (d_rd[g]),
         .d_pmem_write    (d_wr[g]),
         .d_pmem_address  (d_ad[g]),
         .d_pmem_wdata    (d_wd[g]),
         .d_pmem_resp     (d_rsp[g]),
         .d_pmem_rdata    (d_rdt[g]),
         .ab_pmem_read    (ab_rd[g]),
         .ab_pmem_write   (ab_wr[g]),
         .ab_pmem_address (ab_ad[g]),
         .ab_pmem_wdata   (ab_wd[g]),
         .ab_pmem_resp    (ab_rsp[g]),
         .ab_pmem_rdata   (ab_rdt[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         i_rd[k] = 0; i_wr[k] = 0; i_ad[k] = '0; i_wd[k] = '0;
         d_rd[k] = 0; d_wr[k] = 0; d_ad[k] = '0; d_wd[k] = '0;
         ab_rsp[k] = 0; ab_rdt[k] = '0;
      end
      tick();
      tick();
      // reset state
      check_val("rst_ab_read",  ab_rd[0], 0);
      check_val("rst_ab_write", ab_wr[0], 0);
      check_val("rst_ab_addr",  ab_ad[0], 0);
      check_val("rst_ab_wdata", ab_wd[0], 0);
      check_val("rst_i_resp",   i_rsp[0], 0);
      check_val("rst_d_resp",   d_rsp[0], 0);
      reset_n = 1'b1;
      tick();

      // 1: single icache read
      i_rd[0] = 1; i_ad[0] = 32'h0000_1000;
      #1;
      check_val("t1_no_read_yet", ab_rd[0], 0);
      tick();
      check_val("t1_ab_read",  ab_rd[0], 1);
      check_val("t1_ab_write", ab_wr[0], 0);
      check_val("t1_ab_addr",  ab_ad[0], 32'h1000);
      check_val("t1_i_resp_wait", i_rsp[0], 0);
      tick();
      check_val("t1_i_resp_wait2", i_rsp[0], 0);
      tick();
      ab_rsp[0] = 1; ab_rdt[0] = {32{8'hA5}};
      #1;
      check_val("t1_i_resp",  i_rsp[0], 1);
      check_val("t1_i_rdata", i_rdt[0], {32{8'hA5}});
      check_val("t1_d_resp",  d_rsp[0], 0);
      tick();
      i_rd[0] = 0;
      #1;
      check_val("t1_done_ab_read", ab_rd[0], 0);
      check_val("t1_done_resp_ignored", i_rsp[0], 0);
      ab_rsp[0] = 0;
      tick();

      // 2: simultaneous I read / D write, round-robin with last_grant = I
      i_rd[0] = 1; i_ad[0] = 32'h100;
      d_wr[0] = 1; d_ad[0] = 32'h200; d_wd[0] = 256'h1234;
      tick();
      check_val("t2_ab_write", ab_wr[0], 1);
      check_val("t2_ab_read",  ab_rd[0], 0);
      check_val("t2_ab_addr",  ab_ad[0], 32'h200);
      check_val("t2_ab_wdata", ab_wd[0], 256'h1234);
      ab_rsp[0] = 1;
      #1;
      check_val("t2_d_resp", d_rsp[0], 1);
      check_val("t2_i_resp", i_rsp[0], 0);
      tick();
      d_wr[0] = 0; ab_rsp[0] = 0;
      #1;
      check_val("t2_m1_ab_write", ab_wr[0], 0);
      tick();
      check_val("t2_m2_ab_read", ab_rd[0], 0);
      tick();
      check_val("t2_m3_ab_read", ab_rd[0], 1);
      check_val("t2_m3_ab_addr", ab_ad[0], 32'h100);
      ab_rsp[0] = 1;
      #1;
      check_val("t2_i_resp", i_rsp[0], 1);
      check_val("t2_d_resp_off", d_rsp[0], 0);
      tick();
      i_rd[0] = 0; ab_rsp[0] = 0;
      tick();

      // 3: fixed priority, dcache wins three times while icache stays pending
      i_rd[1] = 1; i_ad[1] = 32'h100;
      d_wr[1] = 1; d_ad[1] = 32'h200; d_wd[1] = 256'h1234;
      for (int n = 0; n < 3; n++) begin
         tick();
         check_val("t3_ab_write", ab_wr[1], 1);
         check_val("t3_ab_addr",  ab_ad[1], 32'h200);
         ab_rsp[1] = 1;
         #1;
         check_val("t3_d_resp", d_rsp[1], 1);
         check_val("t3_i_resp", i_rsp[1], 0);
         tick();
         ab_rsp[1] = 0;
         if (n == 2) d_wr[1] = 0;
         #1;
         check_val("t3_done_ab_write", ab_wr[1], 0);
         tick();
      end
      tick();
      check_val("t3_i_ab_read", ab_rd[1], 1);
      check_val("t3_i_ab_addr", ab_ad[1], 32'h100);
      ab_rsp[1] = 1;
      #1;
      check_val("t3_i_resp_final", i_rsp[1], 1);
      tick();
      i_rd[1] = 0; ab_rsp[1] = 0;
      tick();

      // 4: dcache asserts read and write together
      d_rd[0] = 1; d_wr[0] = 1; d_ad[0] = 32'h300;
      tick();
      check_val("t4_ab_write", ab_wr[0], 1);
      check_val("t4_ab_read",  ab_rd[0], 0);
      check_val("t4_ab_addr",  ab_ad[0], 32'h300);
      ab_rsp[0] = 1;
      tick();
      d_rd[0] = 0; d_wr[0] = 0; ab_rsp[0] = 0;
      tick();

      // 5: icache changes address mid-grant; latched address holds
      i_rd[0] = 1; i_ad[0] = 32'h400;
      tick();
      check_val("t5_ab_addr_grant", ab_ad[0], 32'h400);
      i_ad[0] = 32'h999;
      tick();
      check_val("t5_ab_addr_hold1", ab_ad[0], 32'h400);
      tick();
      check_val("t5_ab_addr_hold2", ab_ad[0], 32'h400);
      check_val("t5_ab_read_hold",  ab_rd[0], 1);
      ab_rsp[0] = 1;
      #1;
      check_val("t5_i_resp", i_rsp[0], 1);
      tick();
      i_rd[0] = 0; ab_rsp[0] = 0;
      tick();

      // 6: asynchronous reset in the middle of a dcache grant
      d_rd[0] = 1; d_ad[0] = 32'h500;
      tick();
      check_val("t6_ab_read_pre", ab_rd[0], 1);
      #2;
      reset_n = 1'b0;
      ab_rsp[0] = 1;
      #1;
      check_val("t6_rst_ab_read",  ab_rd[0], 0);
      check_val("t6_rst_ab_write", ab_wr[0], 0);
      check_val("t6_rst_ab_addr",  ab_ad[0], 0);
      check_val("t6_rst_ab_wdata", ab_wd[0], 0);
      check_val("t6_rst_d_resp",   d_rsp[0], 0);
      tick();
      reset_n = 1'b1;
      ab_rsp[0] = 0;
      #1;
      check_val("t6_idle_d_resp", d_rsp[0], 0);
      tick();
      check_val("t6_regrant_read", ab_rd[0], 1);
      check_val("t6_regrant_addr", ab_ad[0], 32'h500);
      ab_rsp[0] = 1;
      #1;
      check_val("t6_d_resp", d_rsp[0], 1);
      tick();
      d_rd[0] = 0; ab_rsp[0] = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
